// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared FSM encoding and width helpers for the switch output arbiter
package switch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } arb_state_e;

  // Port index width; a single-port build still carries a 1-bit id.
  function automatic int id_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // Buffer pointer width; depth is a power of two, so pointers wrap naturally.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width must also hold the value "depth" itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Burst counter must be able to reach max_burst.
  function automatic int burst_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/sw_out_fifo.sv
// rtl/sw_out_fifo.sv - circular output buffer with push/pop, occupancy count and full/empty flags
module sw_out_fifo
  import switch_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // A pop on an empty buffer is ignored; a push into a full buffer is only
  // accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_q] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        tail_q <= tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = mem[head_q];

endmodule

// File: rtl/switch_out_arbiter.sv
// rtl/switch_out_arbiter.sv - round-robin burst drain of switch output ports into an output buffer
module switch_out_arbiter
  import switch_pkg::*;
#(
  parameter int  NUM_OF_PORTS = 4,
  parameter int  WORD_WIDTH   = 8,
  parameter int  BUF_DEPTH    = 4,
  parameter int  MAX_BURST    = 16,
  localparam int ID_W         = id_width(NUM_OF_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_OF_PORTS-1:0]          port_ready,
  input  logic [NUM_OF_PORTS*WORD_WIDTH-1:0] port_out,
  input  logic                             read_out,
  output logic [NUM_OF_PORTS-1:0]          port_read,
  output logic [WORD_WIDTH-1:0]            out_data,
  output logic [ID_W-1:0]                  out_port_id,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             err
);

  localparam int BURST_W = burst_width(MAX_BURST);
  localparam int CNT_W   = cnt_width(BUF_DEPTH);
  localparam int ENTRY_W = ID_W + WORD_WIDTH;

  // rst_n is an active-high reset despite its name.
  logic rst;
  assign rst = rst_n;

  arb_state_e         state_q;
  arb_state_e         state_d;
  logic [ID_W-1:0]    grant_q;
  logic [ID_W-1:0]    last_grant_q;
  logic [ID_W-1:0]    next_grant;
  logic               any_ready;
  logic               grant_ready;
  logic [BURST_W-1:0] burst_cnt_q;
  logic               burst_done;
  logic               rd_q;
  logic [ID_W-1:0]    id_q;
  logic               err_q;
  logic               read_en;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head_entry;
  logic               push;
  logic               pop;
  logic               drop;

  assign any_ready   = |port_ready;
  assign grant_ready = port_ready[grant_q];
  assign burst_done  = (int'(burst_cnt_q) == MAX_BURST);

  // Round-robin search: first ready port after last_grant, wrapping around.
  // Walking offsets from farthest to nearest lets the nearest hit win.
  always_comb begin
    next_grant = last_grant_q;
    for (int i = NUM_OF_PORTS; i >= 1; i--) begin
      if (port_ready[(int'(last_grant_q) + i) % NUM_OF_PORTS]) begin
        next_grant = ID_W'((int'(last_grant_q) + i) % NUM_OF_PORTS);
      end
    end
  end

  // Read strobe: only the granted port, and only while the burst has room and
  // the buffer can take this word on top of any word already in flight.
  always_comb begin
    read_en = 1'b0;
    if (!rst && state_q == DRAIN && grant_ready && int'(burst_cnt_q) < MAX_BURST &&
        (int'(fifo_count) + int'(rd_q)) < BUF_DEPTH) begin
      read_en = 1'b1;
    end
    for (int k = 0; k < NUM_OF_PORTS; k++) begin
      port_read[k] = read_en && (int'(grant_q) == k);
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_ready) state_d = DRAIN;
      DRAIN:   if (!grant_ready || burst_done) state_d = FLUSH;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant and burst tracking; last_grant starts at the top so port 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_OF_PORTS - 1);
      burst_cnt_q  <= '0;
    end else if (state_q == IDLE && any_ready) begin
      grant_q      <= next_grant;
      last_grant_q <= next_grant;
      burst_cnt_q  <= '0;
    end else if (read_en) begin
      burst_cnt_q  <= burst_cnt_q + BURST_W'(1);
    end
  end

  // Write side: accept the returning word only if we actually asked for it and
  // there is (or is about to be) room; anything else is a sticky error.
  always_comb begin
    pop        = !rst && !fifo_empty && out_ready;
    push       = read_out && rd_q && (!fifo_full || pop);
    drop       = read_out && (!rd_q || (fifo_full && !pop));
    push_entry = {id_q, port_out[int'(id_q)*WORD_WIDTH +: WORD_WIDTH]};
  end

  // In-flight read tracking and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= 1'b0;
      id_q  <= '0;
      err_q <= 1'b0;
    end else begin
      rd_q <= read_en;
      if (read_en) begin
        id_q <= grant_q;
      end
      if (drop) begin
        err_q <= 1'b1;
      end
    end
  end

  sw_out_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output view of the buffer head, forced quiet while reset is held.
  always_comb begin
    out_valid   = !rst && !fifo_empty;
    out_data    = rst ? '0 : head_entry[WORD_WIDTH-1:0];
    out_port_id = rst ? '0 : head_entry[ENTRY_W-1 -: ID_W];
    err         = err_q;
  end

endmodule
